// File: rtl/carry_skip_adder.sv
// carry_skip_adder: registered unsigned carry-skip adder, {cout,sum} = a + b + cin.
// The operands are split into BLOCK_W-bit ripple blocks. A block whose bits all
// propagate passes its carry-in straight to its carry-out through a skip mux.
// Optional feature macro: CSA_OVERFLOW_EN adds a registered two's-complement
// overflow flag (ovf). Without the macro there is no ovf port and no overflow logic.
module carry_skip_adder #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned BLOCK_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM_BLK = (BLOCK_W == 0) ? 1 : WIDTH / BLOCK_W;

    // Reject geometries the skip structure cannot represent.
    generate
        if (WIDTH < 1 || BLOCK_W < 1 || (WIDTH % BLOCK_W) != 0) begin : g_bad_cfg
            $error("carry_skip_adder: WIDTH must be >= 1 and a multiple of BLOCK_W");
        end
    endgenerate

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
`ifdef CSA_OVERFLOW_EN
    logic             msb_carry_c;
`endif

    // Combinational core: ripple inside each block, skip mux across fully propagating blocks.
    always_comb begin : p_core
        logic carry;
        logic rip;
        logic blk_p;
        logic pi;
        logic gi;
        sum_c  = '0;
        cout_c = 1'b0;
`ifdef CSA_OVERFLOW_EN
        msb_carry_c = 1'b0;
`endif
        carry = cin;
        rip   = 1'b0;
        blk_p = 1'b0;
        pi    = 1'b0;
        gi    = 1'b0;
        for (int k = 0; k < int'(NUM_BLK); k++) begin
            rip   = carry;
            blk_p = 1'b1;
            for (int i = 0; i < int'(BLOCK_W); i++) begin
                pi = a[k*int'(BLOCK_W) + i] ^ b[k*int'(BLOCK_W) + i];
                gi = a[k*int'(BLOCK_W) + i] & b[k*int'(BLOCK_W) + i];
                sum_c[k*int'(BLOCK_W) + i] = pi ^ rip;
`ifdef CSA_OVERFLOW_EN
                // Ripple carry into the top bit is exact because every block carry-in is exact.
                if (k*int'(BLOCK_W) + i == int'(WIDTH) - 1) begin
                    msb_carry_c = rip;
                end
`endif
                rip   = gi | (pi & rip);
                blk_p = blk_p & pi;
            end
            carry = blk_p ? carry : rip;
        end
        cout_c = carry;
    end

    // Result register: capture on in_valid, otherwise hold data and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_c;
                cout <= cout_c;
`ifdef CSA_OVERFLOW_EN
                ovf  <= msb_carry_c ^ cout_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_carry_skip_adder.sv
// tb_carry_skip_adder: directed table, hold/reset sequences, exhaustive sweep and
// random stream for carry_skip_adder (WIDTH=4, BLOCK_W=2). Set CSA_OVERFLOW_EN to
// exercise the overflow flag as well.
module tb_carry_skip_adder;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CSA_OVERFLOW_EN
    logic         ovf;
`endif

    int total;
    int bad;

    // Expected held state of the registered outputs.
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    carry_skip_adder #(
        .WIDTH  (W),
        .BLOCK_W(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned addition; overflow from signed range of the true result.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        int unsigned u;
        int          s;
        int          sa;
        int          sb;
        u   = int'(ma) + int'(mb) + int'(mc);
        ms  = W'(u);
        mco = (u >= (1 << W));
        sa  = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
        sb  = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
        s   = sa + sb + int'(mc);
        mov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    endtask

    // Drive one cycle of inputs just after a rising edge and wait to the next edge + 1.
    task automatic step(input logic v, input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sc);
        in_valid = v;
        a        = sa;
        b        = sb;
        cin      = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic exp_v);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
        chk({tag, ".sum"},       32'(sum),       32'(exp_sum));
        chk({tag, ".cout"},      32'(cout),      32'(exp_cout));
`ifdef CSA_OVERFLOW_EN
        chk({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
`endif
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] ms;
        logic         mco;
        logic         mov;
        logic         v;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;

        vecs[0] = '{a: 4'h1, b: 4'h2, cin: 1'b0, sum: 4'h3, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 4'h5, b: 4'h3, cin: 1'b0, sum: 4'h8, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 4'hA, b: 4'h5, cin: 1'b1, sum: 4'h0, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 4'hA, b: 4'h5, cin: 1'b0, sum: 4'hF, cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 4'hF, b: 4'h1, cin: 1'b0, sum: 4'h0, cout: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 4'h7, b: 4'h1, cin: 1'b0, sum: 4'h8, cout: 1'b0, ovf: 1'b1};
        vecs[8] = '{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 4'h0, cout: 1'b1, ovf: 1'b1};
        vecs[9] = '{a: 4'h3, b: 4'hC, cin: 1'b1, sum: 4'h0, cout: 1'b1, ovf: 1'b0};

        // Asynchronous reset before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("reset", 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        check_outputs("post_reset_idle", 1'b0);

        // Directed table, back-to-back.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            exp_sum  = vecs[i].sum;
            exp_cout = vecs[i].cout;
            exp_ovf  = vecs[i].ovf;
            check_outputs($sformatf("vec%0d", i), 1'b1);
        end

        // Hold: capture 1001+0110, then idle with junk operands.
        step(1'b1, 4'h9, 4'h6, 1'b0);
        exp_sum  = 4'hF;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_outputs("hold_capture", 1'b1);
        step(1'b0, 4'h7, 4'hE, 1'b1);
        check_outputs("hold_idle1", 1'b0);
        step(1'b0, 4'hF, 4'hF, 1'b1);
        check_outputs("hold_idle2", 1'b0);

        // Asynchronous reset mid-stream, between clock edges.
        step(1'b1, 4'hC, 4'h7, 1'b1);
        model(4'hC, 4'h7, 1'b1, exp_sum, exp_cout, exp_ovf);
        check_outputs("pre_async", 1'b1);
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_outputs("async_reset", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("reset_held", 1'b0);
        rst_n = 1'b1;
        step(1'b0, 4'hF, 4'hF, 1'b1);
        check_outputs("after_release", 1'b0);

        // Exhaustive sweep, one result per cycle.
        for (int ai = 0; ai < (1 << W); ai++) begin
            for (int bi = 0; bi < (1 << W); bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    step(1'b1, W'(ai), W'(bi), 1'(ci));
                    model(W'(ai), W'(bi), 1'(ci), exp_sum, exp_cout, exp_ovf);
                    chk($sformatf("sweep_%0h_%0h_%0d", ai, bi, ci),
                        32'({out_valid, cout, sum}), 32'({1'b1, 5'(ai + bi + ci)}));
`ifdef CSA_OVERFLOW_EN
                    chk($sformatf("sweep_ovf_%0h_%0h_%0d", ai, bi, ci), 32'(ovf), 32'(exp_ovf));
`endif
                end
            end
        end

        // Random stream with gaps in in_valid.
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(3) != 0);
            step(v, W'($urandom), W'($urandom), 1'($urandom));
            if (v) begin
                model(a, b, cin, ms, mco, mov);
                exp_sum  = ms;
                exp_cout = mco;
                exp_ovf  = mov;
            end
            check_outputs($sformatf("rand%0d", n), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
